// File: rtl/fpu8_issue_ctrl.sv
// fpu8_issue_ctrl: issue stage in front of the FPU_8 exception checker and
// arithmetic unit. Requests are queued in a small FIFO. The head entry is held
// in working registers and shown to the exception checker. A flagged operation
// returns EXC_RESULT at once; any other operation launches the arithmetic unit.
// Only one operation is in flight at a time, so results come back in order.
// Optional feature macro: FPU8_ISSUE_TIMEOUT_EN aborts an EXEC phase that runs
// longer than TIMEOUT_CYCLES cycles.
module fpu8_issue_ctrl #(
  parameter int          FIFO_DEPTH     = 4,
  parameter logic [7:0]  EXC_RESULT     = 8'h7F,
  parameter int          TIMEOUT_CYCLES = 15
) (
  input  logic                          clk_i,
  input  logic                          rst_n_i,
  input  logic                          req_valid_i,
  output logic                          req_ready_o,
  input  logic [1:0]                    req_op_i,
  input  logic [7:0]                    req_a_i,
  input  logic [7:0]                    req_b_i,
  output logic [1:0]                    exc_fp_operation_o,
  output logic [7:0]                    exc_op_a_o,
  output logic [7:0]                    exc_op_b_o,
  input  logic                          exc_is_exception_i,
  output logic                          arith_start_o,
  output logic [1:0]                    arith_op_o,
  output logic [7:0]                    arith_a_o,
  output logic [7:0]                    arith_b_o,
  input  logic                          arith_done_i,
  input  logic [7:0]                    arith_result_i,
  output logic                          res_valid_o,
  input  logic                          res_ready_i,
  output logic [7:0]                    res_data_o,
  output logic                          res_exc_o,
  output logic                          res_timeout_o,
  output logic                          busy_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o
);

  localparam int AW = $clog2(FIFO_DEPTH);

  if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) || (TIMEOUT_CYCLES < 1)) begin : g_bad_cfg
    $error("fpu8_issue_ctrl: FIFO_DEPTH must be a power of 2 >= 2 and TIMEOUT_CYCLES >= 1");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CHECK = 2'd1,
    S_EXEC  = 2'd2,
    S_RESP  = 2'd3
  } state_e;

  state_e state_q, state_d;

  // FIFO storage and pointers (one extra pointer bit separates full from empty)
  logic [17:0] fifo_mem_q [FIFO_DEPTH];
  logic [AW:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0] level_s;
  logic        full_s, empty_s, push_s, pop_s;
  logic [17:0] head_s;

  // Working registers and result registers
  logic [1:0] work_op_q, work_op_d;
  logic [7:0] work_a_q, work_a_d, work_b_q, work_b_d;
  logic       start_q, start_d;
  logic [7:0] res_data_q, res_data_d;
  logic       res_exc_q, res_exc_d;
  logic       res_tmo_q, res_tmo_d;
  logic       tmo_hit_s;

  assign level_s = wr_ptr_q - rd_ptr_q;
  assign full_s  = (level_s == (AW+1)'(FIFO_DEPTH));
  assign empty_s = (level_s == '0);
  assign push_s  = req_valid_i && !full_s;
  assign pop_s   = (state_q == S_IDLE) && !empty_s;
  assign head_s  = fifo_mem_q[rd_ptr_q[AW-1:0]];

  // FIFO storage write; contents are don't-care while pointers mark them empty
  always_ff @(posedge clk_i) begin
    if (push_s) begin
      fifo_mem_q[wr_ptr_q[AW-1:0]] <= {req_op_i, req_a_i, req_b_i};
    end
  end

  // FIFO pointer update
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_s) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (pop_s)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end

`ifdef FPU8_ISSUE_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_cnt_q;

  // EXEC cycle counter; stays zero outside EXEC, so it is clear on every entry
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      tmo_cnt_q <= '0;
    end else if (state_q != S_EXEC) begin
      tmo_cnt_q <= '0;
    end else begin
      tmo_cnt_q <= tmo_cnt_q + TW'(1);
    end
  end

  // Last permitted EXEC cycle; a DONE arriving in this same cycle still wins
  assign tmo_hit_s = (state_q == S_EXEC) && (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1));
`else
  assign tmo_hit_s = 1'b0;
`endif

  // State register
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (!empty_s) state_d = S_CHECK;
      S_CHECK: state_d = exc_is_exception_i ? S_RESP : S_EXEC;
      S_EXEC:  if (arith_done_i || tmo_hit_s) state_d = S_RESP;
      S_RESP:  if (res_ready_i) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic: next values for the working, launch and result registers
  always_comb begin
    work_op_d  = work_op_q;
    work_a_d   = work_a_q;
    work_b_d   = work_b_q;
    start_d    = 1'b0;
    res_data_d = res_data_q;
    res_exc_d  = res_exc_q;
    res_tmo_d  = res_tmo_q;
    case (state_q)
      S_IDLE: begin
        if (pop_s) begin
          {work_op_d, work_a_d, work_b_d} = head_s;
        end
      end
      S_CHECK: begin
        if (exc_is_exception_i) begin
          res_data_d = EXC_RESULT;
          res_exc_d  = 1'b1;
          res_tmo_d  = 1'b0;
        end else begin
          start_d = 1'b1;
        end
      end
      S_EXEC: begin
        if (arith_done_i) begin
          res_data_d = arith_result_i;
          res_exc_d  = 1'b0;
          res_tmo_d  = 1'b0;
        end else if (tmo_hit_s) begin
          res_data_d = EXC_RESULT;
          res_exc_d  = 1'b1;
          res_tmo_d  = 1'b1;
        end
      end
      default: begin
      end
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      work_op_q  <= 2'd0;
      work_a_q   <= 8'd0;
      work_b_q   <= 8'd0;
      start_q    <= 1'b0;
      res_data_q <= 8'd0;
      res_exc_q  <= 1'b0;
      res_tmo_q  <= 1'b0;
    end else begin
      work_op_q  <= work_op_d;
      work_a_q   <= work_a_d;
      work_b_q   <= work_b_d;
      start_q    <= start_d;
      res_data_q <= res_data_d;
      res_exc_q  <= res_exc_d;
      res_tmo_q  <= res_tmo_d;
    end
  end

  assign req_ready_o        = !full_s;
  assign fifo_level_o       = level_s;
  assign exc_fp_operation_o = work_op_q;
  assign exc_op_a_o         = work_a_q;
  assign exc_op_b_o         = work_b_q;
  assign arith_op_o         = work_op_q;
  assign arith_a_o          = work_a_q;
  assign arith_b_o          = work_b_q;
  assign arith_start_o      = start_q;
  assign res_valid_o        = (state_q == S_RESP);
  assign res_data_o         = res_data_q;
  assign res_exc_o          = res_exc_q;
  assign res_timeout_o      = res_tmo_q;
  assign busy_o             = (state_q != S_IDLE);

endmodule
